// File: rtl/tspi_pkg.sv
// Shared opcodes, FSM state type and command decode for the SPI target.
package tspi_pkg;

  localparam logic [7:0] TSPI_CMD_READ  = 8'h03;
  localparam logic [7:0] TSPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] TSPI_CMD_ID    = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    ID,
    IGNORE
  } tspi_target_state_e;

  function automatic tspi_target_state_e decodeCmd(input logic [7:0] cmd);
    tspi_target_state_e next;
    case (cmd)
      TSPI_CMD_READ, TSPI_CMD_WRITE: next = ADDR;
      TSPI_CMD_ID:                   next = ID;
      default:                       next = IGNORE;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/tspi_sync_edge.sv
// Two-flop synchroniser followed by a history flop for rise/fall pulse detection.
module tspi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/tspi_target.sv
// SPI mode-0 target serving READ/WRITE/READ_ID against a byte-wide local memory port.
module tspi_target
  import tspi_pkg::*;
#(
  parameter int unsigned AddrWidth = 21,
  parameter logic [7:0]  DeviceId  = 8'hC5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_sck_i,
  input  logic                 spi_cs_ni,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_oe_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [7:0]           mem_wdata_o,
  input  logic [7:0]           mem_rdata_i,
  output logic                 busy_o
);

  logic sckRise, sckFall, unusedSckLevel;
  logic csLevel, csRise, csFall;
  logic mosiSync, unusedMosiRise, unusedMosiFall;

  tspi_sync_edge #(.ResetVal(1'b0)) uSckSync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i),
    .level_o(unusedSckLevel), .rise_o(sckRise), .fall_o(sckFall)
  );

  tspi_sync_edge #(.ResetVal(1'b1)) uCsSync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_cs_ni),
    .level_o(csLevel), .rise_o(csRise), .fall_o(csFall)
  );

  tspi_sync_edge #(.ResetVal(1'b0)) uMosiSync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i),
    .level_o(mosiSync), .rise_o(unusedMosiRise), .fall_o(unusedMosiFall)
  );

  tspi_target_state_e state_q, state_d;
  logic [2:0]           bitCnt_q, bitCnt_d;
  logic [6:0]           rxShift_q, rxShift_d;
  logic [7:0]           txShift_q, txShift_d;
  logic                 misoBit_q, misoBit_d;
  logic [1:0]           addrCnt_q, addrCnt_d;
  logic                 cmdIsRead_q, cmdIsRead_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 memReq_q, memReq_d;
  logic                 memWe_q, memWe_d;
  logic [AddrWidth-1:0] memAddr_q, memAddr_d;
  logic [7:0]           memWdata_q, memWdata_d;
  logic                 rdValid_q, rdValid_d;
  logic [1:0]           settleCnt_q, settleCnt_d;
  logic                 armed_q, armed_d;

  logic                 byteDone;
  logic [7:0]           rxByte;
  logic [AddrWidth-1:0] addrNew;
  logic                 settled;

  assign rxByte   = {rxShift_q, mosiSync};
  assign byteDone = sckRise && (bitCnt_q == 3'd7) && !csRise;
  assign addrNew  = AddrWidth'({addr_q, rxByte});
  assign settled  = (settleCnt_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A frame may only start once CS has been seen high after reset, so a reset
  // in the middle of a frame leaves the rest of that frame unanswered.
  always_comb begin
    state_d = state_q;
    if (csRise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (csFall && armed_q) state_d = CMD;
        CMD:     if (byteDone) state_d = decodeCmd(rxByte);
        ADDR:    if (byteDone && addrCnt_q == 2'd2) state_d = cmdIsRead_q ? RD_DATA : WR_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    spi_miso_oe_o = 1'b0;
    if (state_q == RD_DATA || state_q == ID) begin
      spi_miso_oe_o = 1'b1;
    end
    spi_miso_o = spi_miso_oe_o & misoBit_q;
    busy_o     = !csLevel && (state_q != IDLE);
  end

  always_comb begin
    bitCnt_d    = bitCnt_q;
    rxShift_d   = rxShift_q;
    txShift_d   = txShift_q;
    misoBit_d   = misoBit_q;
    addrCnt_d   = addrCnt_q;
    cmdIsRead_d = cmdIsRead_q;
    addr_d      = addr_q;
    memReq_d    = 1'b0;
    memWe_d     = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    rdValid_d   = 1'b0;
    settleCnt_d = settled ? settleCnt_q : settleCnt_q + 2'd1;
    armed_d     = armed_q | (settled & csLevel);

    if (csRise) begin
      bitCnt_d  = 3'd0;
      misoBit_d = 1'b0;
    end else begin
      if (sckRise && state_q != IDLE) begin
        bitCnt_d  = bitCnt_q + 3'd1;
        rxShift_d = rxByte[6:0];
      end

      if (sckFall && (state_q == RD_DATA || state_q == ID)) begin
        misoBit_d = txShift_q[7];
        txShift_d = {txShift_q[6:0], 1'b0};
      end

      if (byteDone) begin
        case (state_q)
          CMD: begin
            cmdIsRead_d = (rxByte == TSPI_CMD_READ);
            addrCnt_d   = 2'd0;
            if (rxByte == TSPI_CMD_ID) txShift_d = DeviceId;
          end
          ADDR: begin
            addrCnt_d = addrCnt_q + 2'd1;
            addr_d    = addrNew;
            if (addrCnt_q == 2'd2 && cmdIsRead_q) begin
              memReq_d  = 1'b1;
              memAddr_d = addrNew;
              addr_d    = addrNew + AddrWidth'(1);
            end
          end
          RD_DATA: begin
            memReq_d  = 1'b1;
            memAddr_d = addr_q;
            addr_d    = addr_q + AddrWidth'(1);
          end
          WR_DATA: begin
            memReq_d   = 1'b1;
            memWe_d    = 1'b1;
            memAddr_d  = addr_q;
            memWdata_d = rxByte;
            addr_d     = addr_q + AddrWidth'(1);
          end
          ID:      txShift_d = DeviceId;
          default: txShift_d = txShift_d;
        endcase
      end

      // Read data arrives one cycle after the strobe; it is loaded here so it wins
      // over any shift in the same cycle.
      rdValid_d = memReq_q && !memWe_q;
      if (rdValid_q) txShift_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitCnt_q    <= 3'd0;
      rxShift_q   <= 7'd0;
      txShift_q   <= 8'd0;
      misoBit_q   <= 1'b0;
      addrCnt_q   <= 2'd0;
      cmdIsRead_q <= 1'b0;
      addr_q      <= '0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= 8'd0;
      rdValid_q   <= 1'b0;
      settleCnt_q <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      bitCnt_q    <= bitCnt_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      misoBit_q   <= misoBit_d;
      addrCnt_q   <= addrCnt_d;
      cmdIsRead_q <= cmdIsRead_d;
      addr_q      <= addr_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      rdValid_q   <= rdValid_d;
      settleCnt_q <= settleCnt_d;
      armed_q     <= armed_d;
    end
  end

  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_tspi_target.sv
// Frame-level bench for tspi_target: table of SPI frames, memory-op scoreboard, corner-case sequences.
module tb_tspi_target;

  localparam int AddrWidth = 21;
  localparam int Half      = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sck;
  logic                 csN;
  logic                 mosi;
  logic                 miso;
  logic                 oe;
  logic                 memReq;
  logic                 memWe;
  logic [AddrWidth-1:0] memAddr;
  logic [7:0]           memWdata;
  logic [7:0]           memRdata = 8'h00;
  logic                 busy;

  always #5 clk = ~clk;

  tspi_target #(.AddrWidth(AddrWidth), .DeviceId(8'hC5)) dut (
    .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_ni(csN), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(oe), .mem_req_o(memReq), .mem_we_o(memWe),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata), .busy_o(busy)
  );

  typedef struct packed {
    logic [63:0] mosi;
    logic [3:0]  n;
    logic [63:0] miso;
    logic [7:0]  chk;
    logic [7:0]  oeMask;
    logic [3:0]  reqs;
  } vector_t;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           data;
  } memOp_t;

  memOp_t     expQ[$];
  memOp_t     obsQ[$];
  logic [7:0] ramMem [int];
  vector_t    vecs [8];
  int         nApplied    = 0;
  int         nMiscompare = 0;

  // Synchronous RAM: read data is valid in the cycle after the strobe.
  always @(posedge clk) begin
    if (memReq === 1'b1) begin
      if (memWe) ramMem[int'(memAddr)] = memWdata;
      else memRdata <= ramMem.exists(int'(memAddr)) ? ramMem[int'(memAddr)] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (memReq === 1'b1) obsQ.push_back({memWe, memAddr, memWe ? memWdata : 8'h00});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byteAt(input logic [63:0] w, input int i);
    return w[63-8*i -: 8];
  endfunction

  task automatic sendBits(input logic [7:0] tx, input int nBits,
                          output logic [7:0] rx, output logic oeAll, output logic oeAny,
                          output logic stray);
    rx = 8'h00; oeAll = 1'b1; oeAny = 1'b0; stray = 1'b0;
    for (int b = 7; b > 7 - nBits; b--) begin
      mosi = tx[b];
      sck  = 1'b0;
      repeat (Half) @(negedge clk);
      rx    = {rx[6:0], miso};
      oeAll = oeAll & oe;
      oeAny = oeAny | oe;
      if (!oe && miso) stray = 1'b1;
      sck = 1'b1;
      repeat (Half) @(negedge clk);
    end
  endtask

  task automatic endFrame();
    sck = 1'b0;
    repeat (Half) @(negedge clk);
    csN = 1'b1;
    repeat (2 * Half) @(negedge clk);
  endtask

  // Reference model: derive the memory operations a frame must produce.
  task automatic modelFrame(input vector_t v);
    logic [7:0]           cmd;
    logic [23:0]          a24;
    logic [AddrWidth-1:0] a;
    cmd = byteAt(v.mosi, 0);
    if ((cmd == 8'h02 || cmd == 8'h03) && v.n >= 4) begin
      a24 = {byteAt(v.mosi, 1), byteAt(v.mosi, 2), byteAt(v.mosi, 3)};
      a   = a24[AddrWidth-1:0];
      if (cmd == 8'h02) begin
        for (int i = 4; i < int'(v.n); i++) begin
          expQ.push_back({1'b1, a, byteAt(v.mosi, i)});
          a = a + 1'b1;
        end
      end else begin
        for (int i = 4; i <= int'(v.n); i++) begin
          expQ.push_back({1'b0, a, 8'h00});
          a = a + 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input vector_t v, input string name);
    logic [7:0] rx;
    logic       oeAll, oeAny, stray;
    logic       strayAny;
    memOp_t     e, o;
    strayAny = 1'b0;
    modelFrame(v);
    csN = 1'b0;
    repeat (Half) @(negedge clk);
    for (int i = 0; i < int'(v.n); i++) begin
      sendBits(byteAt(v.mosi, i), 8, rx, oeAll, oeAny, stray);
      strayAny = strayAny | stray;
      if (v.chk[i]) checkOutput($sformatf("%s miso byte %0d", name, i), 64'(rx), 64'(byteAt(v.miso, i)));
      checkOutput($sformatf("%s oe byte %0d", name, i), v.oeMask[i] ? 64'(oeAll) : 64'(oeAny), 64'(v.oeMask[i]));
    end
    endFrame();
    checkOutput($sformatf("%s req count", name), 64'(obsQ.size()), 64'(v.reqs));
    checkOutput($sformatf("%s miso while oe=0", name), 64'(strayAny), 64'd0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (obsQ.size() == 0) begin
        checkOutput($sformatf("%s missing mem op", name), 64'd0, 64'(e));
      end else begin
        o = obsQ.pop_front();
        checkOutput($sformatf("%s mem op", name), 64'(o), 64'(e));
      end
    end
    obsQ.delete();
  endtask

  initial begin
    logic [7:0] rx;
    logic       oeAll, oeAny, stray;
    vector_t    idVec;

    ramMem[32'h20]     = 8'h5A;
    ramMem[32'h21]     = 8'hA5;
    ramMem[32'h1FFFFF] = 8'h3C;
    ramMem[32'h0]      = 8'hC3;

    vecs[0] = '{mosi: 64'h02_00_00_10_AA_BB_00_00, n: 4'd6, miso: 64'h0, chk: 8'h00, oeMask: 8'h00, reqs: 4'd2};
    vecs[1] = '{mosi: 64'h03_00_00_20_00_00_00_00, n: 4'd6, miso: 64'h00_00_00_00_5A_A5_00_00, chk: 8'h30, oeMask: 8'h30, reqs: 4'd3};
    vecs[2] = '{mosi: 64'h03_1F_FF_FF_00_00_00_00, n: 4'd6, miso: 64'h00_00_00_00_3C_C3_00_00, chk: 8'h30, oeMask: 8'h30, reqs: 4'd3};
    vecs[3] = '{mosi: 64'h9F_00_00_00_00_00_00_00, n: 4'd3, miso: 64'h00_C5_C5_00_00_00_00_00, chk: 8'h06, oeMask: 8'h06, reqs: 4'd0};
    vecs[4] = '{mosi: 64'h55_00_00_00_00_00_00_00, n: 4'd4, miso: 64'h0, chk: 8'h00, oeMask: 8'h00, reqs: 4'd0};
    vecs[5] = '{mosi: 64'h03_E0_00_20_00_00_00_00, n: 4'd5, miso: 64'h00_00_00_00_5A_00_00_00, chk: 8'h10, oeMask: 8'h10, reqs: 4'd2};
    vecs[6] = '{mosi: 64'h02_00_00_11_77_00_00_00, n: 4'd5, miso: 64'h0, chk: 8'h00, oeMask: 8'h00, reqs: 4'd1};
    vecs[7] = '{mosi: 64'h03_00_00_10_00_00_00_00, n: 4'd6, miso: 64'h00_00_00_00_AA_77_00_00, chk: 8'h30, oeMask: 8'h30, reqs: 4'd3};

    // Reset held with CS low and SCK toggling.
    rst = 1'b1; csN = 1'b0; sck = 1'b0; mosi = 1'b0;
    repeat (2) begin
      sck = ~sck;
      @(negedge clk);
    end
    checkOutput("reset spi outs", {62'd0, miso, oe}, 64'd0);
    checkOutput("reset mem outs", {memReq, memWe, memAddr, memWdata}, 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (6) begin
      sck = ~sck;
      repeat (Half) @(negedge clk);
    end
    checkOutput("post-reset busy", 64'(busy), 64'd0);
    endFrame();
    checkOutput("post-reset req count", 64'(obsQ.size()), 64'd0);
    obsQ.delete();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a write frame: the rest of the frame must be ignored.
    csN = 1'b0;
    repeat (Half) @(negedge clk);
    sendBits(8'h02, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h00, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h00, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h40, 8, rx, oeAll, oeAny, stray);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    sendBits(8'h11, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h22, 8, rx, oeAll, oeAny, stray);
    checkOutput("midreset oe", 64'(oeAny), 64'd0);
    checkOutput("midreset busy late", 64'(busy), 64'd0);
    endFrame();
    checkOutput("midreset req count", 64'(obsQ.size()), 64'd0);
    obsQ.delete();

    // Abort a write after 5 bits of the data byte.
    csN = 1'b0;
    repeat (Half) @(negedge clk);
    sendBits(8'h02, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h00, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h00, 8, rx, oeAll, oeAny, stray);
    sendBits(8'h30, 8, rx, oeAll, oeAny, stray);
    sendBits(8'hFF, 5, rx, oeAll, oeAny, stray);
    endFrame();
    checkOutput("abort req count", 64'(obsQ.size()), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    obsQ.delete();

    idVec = '{mosi: 64'h9F_00_00_00_00_00_00_00, n: 4'd2, miso: 64'h00_C5_00_00_00_00_00_00, chk: 8'h02, oeMask: 8'h02, reqs: 4'd0};
    applyStimulus(idVec, "id after abort");
    checkOutput("idle oe", 64'(oe), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
